// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package wrr_arb_pkg;

  // Arbitration policy selected by i_mode
  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mode_e;

  // Grant FSM states
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Widest one-hot vector the index helper accepts
  localparam int unsigned OH_MAX_W = 64;

  // Binary index of the set bit in a one-hot vector (0 when the vector is zero)
  function automatic int unsigned onehot_to_idx(input logic [OH_MAX_W-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < OH_MAX_W; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/wrr_arb_rr_pick.sv
// Combinational find-first-set over a request vector, searching upward from
// a start pointer and wrapping at N-1 -> 0. Tie the pointer to 0 for a plain
// lowest-index priority encoder.
module rr_pick
  import wrr_arb_pkg::*;
#(
  parameter  int unsigned N  = 8,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_c_o,
  output logic [IW-1:0] gnt_idx_c_o
);

  logic          found;
  logic [IW-1:0] k;

  // Walk the requesters in rotated order and keep the first one seen
  always_comb begin
    gnt_oh_c_o = '0;
    found      = 1'b0;
    k          = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = IW'((32'(ptr_i) + i) % N);
      if (!found && req_i[k]) begin
        found         = 1'b1;
        gnt_oh_c_o[k] = 1'b1;
      end
    end
  end

  assign gnt_idx_c_o = IW'(onehot_to_idx(OH_MAX_W'(gnt_oh_c_o)));

endmodule

// File: rtl/wrr_arb.sv
// Weighted round-robin / fixed-priority arbiter with a registered one-hot
// grant held for (weight+1) accepted beats per owner.
// Optional feature: define WRR_ARB_LOCK_EN to add i_lock, which keeps the
// current owner across accepted beats regardless of credit or request.
module wrr_arb
  import wrr_arb_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 8,
  parameter int unsigned WEIGHT_W   = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_INPUTS-1:0]          i_req,
  input  logic                           i_valid,
  input  logic [NUM_INPUTS*WEIGHT_W-1:0] i_weight,
  input  logic                           i_mode,
  input  logic                           i_ready,
`ifdef WRR_ARB_LOCK_EN
  input  logic                           i_lock,
`endif
  output logic [NUM_INPUTS-1:0]          o_grant,
  output logic                           o_valid,
  output logic [$clog2(NUM_INPUTS)-1:0]  o_owner
);

  localparam int unsigned IW = $clog2(NUM_INPUTS);
  localparam int unsigned CW = WEIGHT_W + 1;

  state_e                state_q, state_d;
  logic [NUM_INPUTS-1:0] grant_q, grant_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [IW-1:0]         ptr_q,   ptr_d;
  logic [CW-1:0]         credit_q, credit_d;

  logic [NUM_INPUTS-1:0] rr_oh, fx_oh, win_oh;
  logic [IW-1:0]         rr_idx, fx_idx, win_idx;
  logic [WEIGHT_W-1:0]   win_weight;
  logic                  fixed_c;
  logic                  lock_c;
  logic                  owner_req_c;
  logic                  credit_nz_c;
  logic                  load;

  // Rotating search from the pointer for round-robin mode
  rr_pick #(.N(NUM_INPUTS)) u_pick_rr (
    .req_i      (i_req),
    .ptr_i      (ptr_q),
    .gnt_oh_c_o (rr_oh),
    .gnt_idx_c_o(rr_idx)
  );

  // Same search anchored at index 0 gives fixed priority
  rr_pick #(.N(NUM_INPUTS)) u_pick_fx (
    .req_i      (i_req),
    .ptr_i      ('0),
    .gnt_oh_c_o (fx_oh),
    .gnt_idx_c_o(fx_idx)
  );

`ifdef WRR_ARB_LOCK_EN
  assign lock_c = i_lock;
`else
  assign lock_c = 1'b0;
`endif

  assign fixed_c     = (mode_e'(i_mode) == MODE_FIXED);
  assign win_oh      = fixed_c ? fx_oh  : rr_oh;
  assign win_idx     = fixed_c ? fx_idx : rr_idx;
  assign win_weight  = i_weight[win_idx*WEIGHT_W +: WEIGHT_W];
  assign owner_req_c = i_req[owner_q];
  assign credit_nz_c = |credit_q;

  // Next-state: hold on stall, extend burst while credit lasts, else re-arbitrate
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    load     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_valid && |i_req) load = 1'b1;
      end
      GRANT: begin
        if (i_ready) begin
          if (i_valid && (lock_c || (owner_req_c && credit_nz_c))) begin
            // Credit saturates at zero so a locked burst can run on indefinitely
            credit_d = credit_nz_c ? credit_q - CW'(1) : '0;
          end else if (i_valid && |i_req) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            owner_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d  = GRANT;
      grant_d  = win_oh;
      owner_d  = win_idx;
      credit_d = CW'(win_weight);
      if (!fixed_c) ptr_d = IW'((32'(win_idx) + 32'd1) % NUM_INPUTS);
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  assign o_grant = grant_q;
  assign o_valid = (state_q == GRANT);
  assign o_owner = owner_q;

endmodule

// File: tb/tb_wrr_arb.sv
// Scoreboard bench for wrr_arb: each stimulus step queues the grant expected
// after the next clock edge; a monitor pops and checks one entry per edge.
module tb_wrr_arb;

  localparam int unsigned N  = 8;
  localparam int unsigned WW = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic [N-1:0]      i_req;
  logic              i_valid;
  logic [N*WW-1:0]   i_weight;
  logic              i_mode;
  logic              i_ready;
  logic [N-1:0]      o_grant;
  logic              o_valid;
  logic [2:0]        o_owner;
`ifdef WRR_ARB_LOCK_EN
  logic              i_lock;
  logic              lock_s;
`endif

  // Staged side inputs, applied at the next step together with the request
  logic              mode_s;
  logic [N*WW-1:0]   weight_s;

  logic [7:0]        exp_q[$];
  int unsigned       n_cmp = 0;
  int unsigned       n_bad = 0;

  logic [7:0]        wrr_seq [10] = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h04,
                                      8'h02, 8'h02, 8'h02, 8'h02, 8'h04};

  wrr_arb #(.NUM_INPUTS(N), .WEIGHT_W(WW)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_req   (i_req),
    .i_valid (i_valid),
    .i_weight(i_weight),
    .i_mode  (i_mode),
    .i_ready (i_ready),
`ifdef WRR_ARB_LOCK_EN
    .i_lock  (i_lock),
`endif
    .o_grant (o_grant),
    .o_valid (o_valid),
    .o_owner (o_owner)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] idx_of(input logic [7:0] g);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  task automatic set_w(input int k, input logic [WW-1:0] w);
    weight_s[k*WW +: WW] = w;
  endtask

  // Drive one cycle of inputs and queue the grant expected after the edge
  task automatic step(input logic r_n, input logic [7:0] req, input logic v,
                      input logic rdy, input logic [7:0] want);
    @(negedge clk);
    rstn     = r_n;
    i_req    = req;
    i_valid  = v;
    i_ready  = rdy;
    i_mode   = mode_s;
    i_weight = weight_s;
`ifdef WRR_ARB_LOCK_EN
    i_lock   = lock_s;
`endif
    exp_q.push_back(want);
  endtask

  // Monitor: check registered outputs just after every active edge
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (o_grant !== e || o_valid !== (|e) || o_owner !== idx_of(e)) begin
          n_bad++;
          $display("FAIL beat%0d: got grant=%h valid=%b owner=%0d, want grant=%h valid=%b owner=%0d",
                   n_cmp, o_grant, o_valid, o_owner, e, |e, idx_of(e));
        end
      end
    end
  end

  initial begin
    rstn = 1'b0; i_req = '0; i_valid = 1'b0; i_ready = 1'b0;
    i_mode = 1'b0; i_weight = '0; mode_s = 1'b0; weight_s = '0;
`ifdef WRR_ARB_LOCK_EN
    i_lock = 1'b0; lock_s = 1'b0;
`endif

    // Reset with every requester asserted; first grant goes to index 0
    repeat (3) step(1'b0, 8'hFF, 1'b1, 1'b1, 8'h00);
    step(1'b1, 8'hFF, 1'b1, 1'b1, 8'h01);

    // Round-robin, all weights 0: one beat each, no bubbles, wraps to 01
    for (int i = 1; i <= 8; i++) step(1'b1, 8'hFF, 1'b1, 1'b1, 8'(1 << (i % 8)));
    step(1'b1, 8'hFF, 1'b0, 1'b1, 8'h00);
    step(1'b1, 8'hFF, 1'b0, 1'b1, 8'h00);

    // Weight 3 on requester 1 gives 4-beat bursts (pointer starts at 1)
    set_w(1, 4'd3);
    for (int i = 0; i < 10; i++) step(1'b1, 8'h06, 1'b1, 1'b1, wrr_seq[i]);
    step(1'b1, 8'h06, 1'b0, 1'b1, 8'h00);

    // Stall keeps grant and credit; mode/weight changes ignored mid-burst
    step(1'b1, 8'h06, 1'b1, 1'b0, 8'h02);
    mode_s = 1'b1; set_w(1, 4'd0);
    step(1'b1, 8'h06, 1'b1, 1'b0, 8'h02);
    step(1'b1, 8'h06, 1'b1, 1'b0, 8'h02);
    mode_s = 1'b0;
    step(1'b1, 8'h06, 1'b1, 1'b0, 8'h02);
    step(1'b1, 8'h06, 1'b1, 1'b1, 8'h02);
    step(1'b1, 8'h06, 1'b1, 1'b1, 8'h02);
    step(1'b1, 8'h06, 1'b1, 1'b1, 8'h02);
    step(1'b1, 8'h06, 1'b1, 1'b1, 8'h04);
    // New weight 0 on requester 1 now applies: single beat
    step(1'b1, 8'h06, 1'b1, 1'b1, 8'h02);
    step(1'b1, 8'h06, 1'b1, 1'b1, 8'h04);
    step(1'b1, 8'h06, 1'b0, 1'b1, 8'h00);

    // Owner request drops during a 5-cycle stall: grant held, re-arbitrate on accept
    set_w(2, 4'd2);
    step(1'b1, 8'h04, 1'b1, 1'b0, 8'h04);
    repeat (5) step(1'b1, 8'h00, 1'b1, 1'b0, 8'h04);
    step(1'b1, 8'h02, 1'b1, 1'b1, 8'h02);
    step(1'b1, 8'h00, 1'b1, 1'b1, 8'h00);

    // Fixed priority leaves the pointer alone (pointer parked at 5)
    set_w(2, 4'd0);
    step(1'b1, 8'h10, 1'b1, 1'b1, 8'h10);
    step(1'b1, 8'h10, 1'b0, 1'b1, 8'h00);
    mode_s = 1'b1;
    repeat (3) step(1'b1, 8'h94, 1'b1, 1'b1, 8'h04);
    mode_s = 1'b0;
    step(1'b1, 8'h94, 1'b1, 1'b1, 8'h80);
    step(1'b1, 8'h94, 1'b1, 1'b1, 8'h04);
    step(1'b1, 8'h94, 1'b1, 1'b1, 8'h10);
    step(1'b1, 8'h94, 1'b1, 1'b1, 8'h80);
    step(1'b1, 8'h94, 1'b0, 1'b1, 8'h00);

    // i_valid low ends a burst after the current beat despite remaining credit
    set_w(1, 4'd3);
    step(1'b1, 8'h02, 1'b1, 1'b1, 8'h02);
    step(1'b1, 8'h02, 1'b0, 1'b1, 8'h00);
    step(1'b1, 8'h02, 1'b1, 1'b0, 8'h02);
    step(1'b1, 8'h02, 1'b0, 1'b0, 8'h02);
    step(1'b1, 8'h02, 1'b0, 1'b1, 8'h00);

    // Reset mid-burst abandons it and clears the pointer
    step(1'b1, 8'h02, 1'b1, 1'b1, 8'h02);
    step(1'b1, 8'h02, 1'b1, 1'b1, 8'h02);
    step(1'b0, 8'h02, 1'b1, 1'b1, 8'h00);
    step(1'b1, 8'h06, 1'b1, 1'b1, 8'h02);
    step(1'b1, 8'h06, 1'b1, 1'b1, 8'h02);
    step(1'b1, 8'h06, 1'b0, 1'b1, 8'h00);

`ifdef WRR_ARB_LOCK_EN
    // Lock holds a weight-0 owner for 6 beats, even with its request dropped
    set_w(1, 4'd0);
    lock_s = 1'b1;
    step(1'b1, 8'h03, 1'b1, 1'b1, 8'h01);
    step(1'b1, 8'h03, 1'b1, 1'b1, 8'h01);
    step(1'b1, 8'h02, 1'b1, 1'b1, 8'h01);
    step(1'b1, 8'h02, 1'b1, 1'b1, 8'h01);
    step(1'b1, 8'h03, 1'b1, 1'b1, 8'h01);
    step(1'b1, 8'h03, 1'b1, 1'b1, 8'h01);
    lock_s = 1'b0;
    step(1'b1, 8'h03, 1'b1, 1'b1, 8'h02);
    step(1'b1, 8'h03, 1'b0, 1'b1, 8'h00);
`endif

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wrr_arb.md
# wrr_arb

Parametrised weighted round-robin arbiter, successor to the single-beat round-robin arbiter used in the request-arbitration path. It selects one of NUM_INPUTS requesters and holds the grant for a programmable number of accepted beats per requester. A downstream ready handshake stalls the grant, and run-time selectable round-robin or fixed-priority mode is supported. It sits between the requester bank and the shared resource, driving a registered one-hot grant.

## Interface
- NUM_INPUTS, 8, number of requesters (>=2)
- WEIGHT_W, 4, width of each per-requester weight field
- clk  input  1  clock; all logic on posedge
- rstn  input  1  synchronous, active-low reset
- i_req  input  NUM_INPUTS  request vector; bit k = requester k
- i_valid  input  1  arbitration enable; when low, no new grant is issued
- i_weight  input  NUM_INPUTS*WEIGHT_W  packed weights; requester k at [k*WEIGHT_W +: WEIGHT_W]
- i_mode  input  1  0 = weighted round-robin, 1 = fixed priority (index 0 highest)
- i_ready  input  1  downstream accepts the current grant beat
- o_grant  output  NUM_INPUTS  registered one-hot grant
- o_valid  output  1  o_grant holds a valid grant
- o_owner  output  $clog2(NUM_INPUTS)  binary index of granted requester

## Operation
- Clock and reset: one clock `clk`; reset `rstn` is synchronous and active-low.
- State: IDLE (o_valid=0) and GRANT (o_valid=1). Internal state: rr pointer, beat credit counter of WEIGHT_W+1 bits.
- Beat accepted = o_valid && i_ready.
- IDLE -> GRANT when i_valid && |i_req. The winner is chosen by the current mode. Credit is loaded with the winner's weight.
- GRANT, not accepted: o_grant, o_owner and o_valid are held unchanged, even if i_req for the owner drops or i_weight/i_mode changes.
- GRANT, accepted, owner still requesting, credit != 0, i_valid=1: keep owner and decrement credit.
- GRANT, accepted, otherwise: re-arbitrate in the same edge.
  - If i_valid && |i_req: load the new winner (GRANT -> GRANT, no bubble).
  - Else: go to IDLE and set o_grant=0.
- Weight w gives w+1 consecutive accepted beats; weight 0 gives 1 beat.
- Weight is sampled only at grant load; mid-burst changes take effect at the next grant.
- RR winner: first set bit of i_req searching upward from pointer, wrapping NUM_INPUTS-1 -> 0.
- The pointer is updated to winner+1 (mod NUM_INPUTS) on every grant load in RR mode. Fixed mode does not modify the pointer.
- Fixed winner: lowest set index of i_req.
- A burst owner re-arbitrated while still requesting competes normally. In RR mode it has lowest priority.
- i_valid low during GRANT: the current beat completes normally; after acceptance the arbiter goes to IDLE regardless of credit.

## Timing
- Reset (rstn=0 at a posedge): o_grant=0, o_valid=0, o_owner=0, pointer=0, credit=0, state IDLE. Reset mid-burst abandons the burst at that edge.
- Latency: requests sampled at edge n produce o_grant/o_valid valid after edge n. One cycle from request to grant.
- Back-to-back grants to different requesters have zero idle cycles.
- o_grant is always one-hot or zero. o_valid equals |o_grant.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- WRR_ARB_LOCK_EN defined: adds port i_lock (input, 1).
  - While o_valid && i_lock, an accepted beat keeps the current owner even when credit reaches 0 or the owner's request drops.
  - Credit saturates at 0.
  - Lock is ignored in IDLE.
- Not defined: no i_lock port. Bursts end strictly per the credit/request rules above.

## Structure
- Package `wrr_arb_pkg`: mode enum (MODE_RR=0, MODE_FIXED=1), state enum (IDLE, GRANT), and function onehot-to-index.
- Sub-module `rr_pick`: combinational masked find-first-set. Inputs are request vector and start pointer; outputs are one-hot and index.
- Fixed mode reuses `rr_pick` with pointer tied to 0.

## Test plan
- Reset with i_req=8'hFF held -> o_valid=0, o_grant=0 for every reset cycle; first grant after release is 8'h01.
- RR, all weights 0, i_req=8'hFF, i_ready=1 -> grants 01,02,04,...,80,01 on consecutive cycles with no bubble.
- RR, weight[1]=3, others 0, i_req=8'h06, i_ready=1 -> 02 for 4 cycles, 04 for 1 cycle, 02 for 4 cycles.
- i_ready=0 for 5 cycles mid-burst while i_req owner bit drops -> o_grant held stable, credit unchanged; after i_ready=1, arbiter re-arbitrates on that edge.
- i_mode=1, i_req=8'h84, weights 0 -> 04 on every grant; switch to i_mode=0 -> next grant 80 per pointer.
- WRR_ARB_LOCK_EN defined, weight[0]=0, i_lock=1 for 6 accepted beats -> 01 held 6 beats; lock released -> next requester granted on following edge.
